morse_compose: RTL and testbench

//  Morse keyer receiver: samples a push-button key, classifies each debounced press as short or long,
//  and packs up to 5 symbols into the 10-bit code word the audio path plays back (2 bits per symbol).

---
 rtl/morse_compose.sv | 123 ++++++++++++
 tb/tb_morse_compose.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/morse_compose.sv
// Morse keyer receiver: synchronise + debounce key, time presses/gaps, pack up to 5 symbols per letter.
// Press-to-key_led latency 2+DEB_CYC; letter published one cycle after the closing gap; ack clears ready.
module morse_compose #(
    parameter int DEB_CYC  = 1000,
    parameter int LONG_MIN = 6000000,
    parameter int GAP_MIN  = 12000000,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       ack,
    output logic [9:0] code,
    output logic       ready,
    output logic       overrun,
    output logic       err,
    output logic       key_led
);

    localparam int DW = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    logic             sync1, sync2;
    logic [DW-1:0]    deb_cnt;
    state_t           state, next_state;
    logic [CNT_W-1:0] dur;
    logic [9:0]       sreg;
    logic [2:0]       nsym;
    logic             pend_err;
    logic             dur_clr, sym_done, do_emit;
    logic [1:0]       sym;
    logic [9:0]       slot_val;

    // Synchroniser idles at the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb_cnt <= '0;
            key_led <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (~sync2 == key_led) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
                key_led <= ~sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (key_led) next_state = PRESS;
            PRESS:   if (!key_led) next_state = GAP;
            GAP: begin
                if (key_led)                          next_state = PRESS;
                else if (dur == CNT_W'(GAP_MIN))      next_state = EMIT;
            end
            EMIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sym_done = (state == PRESS) && !key_led;
        do_emit  = (state == EMIT);
        dur_clr  = (state == IDLE) || (next_state != state);
    end

    assign sym      = (dur >= CNT_W'(LONG_MIN)) ? 2'b10 : 2'b01;
    assign slot_val = {sym, 8'b0} >> {nsym, 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dur      <= '0;
            sreg     <= '0;
            nsym     <= '0;
            pend_err <= 1'b0;
            code     <= '0;
            err      <= 1'b0;
            ready    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (dur_clr)         dur <= '0;
            else if (dur != '1)  dur <= dur + 1'b1;

            if (sym_done) begin
                if (nsym < 3'd5) begin
                    sreg <= sreg | slot_val;
                    nsym <= nsym + 3'd1;
                end else begin
                    pend_err <= 1'b1;
                end
            end

            // A same-cycle ack means the previous letter was read, so it is not an overrun.
            if (do_emit) begin
                code     <= sreg;
                err      <= pend_err;
                overrun  <= ready & ~ack;
                ready    <= 1'b1;
                sreg     <= '0;
                nsym     <= '0;
                pend_err <= 1'b0;
            end else if (ack && ready) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_compose.sv
// Self-checking bench for morse_compose with shortened timing parameters.
module tb_morse_compose;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       ack;
    logic [9:0] code;
    logic       ready, overrun, err, key_led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] code;
        logic       err;
        logic       ovr;
    } exp_t;

    exp_t sb[$];

    morse_compose #(.DEB_CYC(4), .LONG_MIN(20), .GAP_MIN(40), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .ack(ack),
        .code(code), .ready(ready), .overrun(overrun), .err(err), .key_led(key_led)
    );

    always #5 clk = ~clk;

    task automatic press(input int n);
        key_n = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_key(input int n);
        key_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_letter(input logic [9:0] c, input logic e, input logic o);
        exp_t x;
        x.code = c; x.err = e; x.ovr = o;
        sb.push_back(x);
    endtask

    task automatic check_letter(input string name);
        exp_t x;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        x = sb.pop_front();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, ready); end
        checks++;
        if (code !== x.code) begin errors++; $display("FAIL %s code: got %b want %b", name, code, x.code); end
        checks++;
        if (err !== x.err) begin errors++; $display("FAIL %s err: got %b want %b", name, err, x.err); end
        checks++;
        if (overrun !== x.ovr) begin errors++; $display("FAIL %s overrun: got %b want %b", name, overrun, x.ovr); end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; key_n = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({code, ready, overrun, err, key_led} !== 14'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b want 0", {code, ready, overrun, err, key_led});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, key_led} !== 2'b00) begin
            errors++; $display("FAIL post-reset idle: got %b want 00", {ready, key_led});
        end
    endtask

    task automatic test_single_short();
        int lat;
        lat = 0;
        key_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (key_led === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat != 6) begin errors++; $display("FAIL key_led latency: got %0d want 6", lat); end
        repeat (4) @(negedge clk);
        expect_letter(10'b01_00_00_00_00, 1'b0, 1'b0);
        release_key(60);
        check_letter("single_short");
        pulse_ack();
    endtask

    task automatic test_letter_a();
        press(10); release_key(15); press(30);
        expect_letter(10'b01_10_00_00_00, 1'b0, 1'b0);
        release_key(60);
        check_letter("letter_a");
        repeat (10) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL a_hold ready: got %b want 1", ready); end
        pulse_ack();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL a_ack ready: got %b want 0", ready); end
        checks++;
        if (code !== 10'b01_10_00_00_00) begin
            errors++; $display("FAIL a_ack code held: got %b want 0110000000", code);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        press(3);
        key_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (key_led === 1'b1 || ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch: got key_led/ready activity 1 want 0"); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin press(10); release_key(15); end
        press(10);
        expect_letter(10'b01_01_01_01_01, 1'b1, 1'b0);
        release_key(60);
        check_letter("overflow");
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        press(10);
        expect_letter(10'b01_00_00_00_00, 1'b0, 1'b0);
        release_key(60);
        check_letter("b2b_first");
        press(10); release_key(15); press(30);
        expect_letter(10'b01_10_00_00_00, 1'b0, 1'b1);
        release_key(60);
        check_letter("b2b_second");
        pulse_ack();
        checks++;
        if ({ready, overrun} !== 2'b00) begin
            errors++; $display("FAIL b2b_ack ready/overrun: got %b want 00", {ready, overrun});
        end
    endtask

    task automatic test_mid_reset();
        press(10); release_key(15); press(8);
        reset = 1'b0;
        #1;
        checks++;
        if ({code, ready, overrun, err, key_led} !== 14'b0) begin
            errors++;
            $display("FAIL mid_reset outputs: got %b want 0", {code, ready, overrun, err, key_led});
        end
        key_n = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        press(10);
        expect_letter(10'b01_00_00_00_00, 1'b0, 1'b0);
        release_key(60);
        check_letter("after_reset");
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_single_short();
        test_letter_a();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
